// File: rtl/intr_pkg.sv
// Shared defaults and helpers for the nested interrupt controller.
// Imported by the controller top and its priority encoder.
package intr_pkg;

    localparam int unsigned DEF_N_IRQ      = 8;
    localparam int unsigned DEF_NEST_DEPTH = 4;
    localparam logic [15:0] DEF_VEC_BASE   = 16'h0F00;
    localparam logic [15:0] DEF_VEC_STRIDE = 16'h0010;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 32'd2) ? 32'd1 : $clog2(value);
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
// Reports whether any request is set plus the winning index.
module intr_prio_enc #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the lowest-priority end so the lowest index overwrites last.
    always_comb begin
        valid = 1'b0;
        idx   = {IW{1'b0}};
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl_nested.sv
// Nested interrupt controller: edge-latched requests, mask, fixed priority and an
// in-service stack that only lets strictly higher-priority lines preempt.
module intr_ctrl_nested
    import intr_pkg::*;
#(
    parameter int unsigned N_IRQ            = DEF_N_IRQ,
    parameter int unsigned NEST_DEPTH       = DEF_NEST_DEPTH,
    parameter int unsigned ADDR_W           = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(DEF_VEC_STRIDE)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_IRQ-1:0]                       intr_in,
    input  logic                                   mask_we,
    input  logic [N_IRQ-1:0]                       mask_in,
    input  logic                                   ack,
    input  logic                                   ret,
    output logic                                   irq_req,
    output logic [clog2_min1(N_IRQ)-1:0]           irq_id,
    output logic [ADDR_W-1:0]                      irq_vector,
    output logic [N_IRQ-1:0]                       in_service,
    output logic [clog2_min1(NEST_DEPTH+1)-1:0]    nest_level,
    output logic                                   proto_err
);

    localparam int unsigned ID_W  = clog2_min1(N_IRQ);
    localparam int unsigned LVL_W = clog2_min1(NEST_DEPTH + 1);
    localparam logic [N_IRQ-1:0] ONE_HOT0 = {{(N_IRQ-1){1'b0}}, 1'b1};

    logic [N_IRQ-1:0] sync_r;
    logic [N_IRQ-1:0] prev_r;
    logic [N_IRQ-1:0] pending_r;
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] in_service_r;
    logic [ID_W-1:0]  stack_r [NEST_DEPTH];
    logic [LVL_W-1:0] nest_level_r;
    logic             proto_err_r;

    logic [N_IRQ-1:0] eligible_s;
    logic [N_IRQ-1:0] edge_s;
    logic [N_IRQ-1:0] push_mask_s;
    logic [N_IRQ-1:0] pop_mask_s;
    logic             win_valid_s;
    logic [ID_W-1:0]  win_idx_s;
    logic [ID_W-1:0]  top_s;
    logic [ID_W-1:0]  id_s;
    logic             stack_empty_s;
    logic             req_s;
    logic             push_s;
    logic             pop_s;
    logic             err_s;

    assign eligible_s = pending_r & mask_r;
    assign edge_s     = sync_r & ~prev_r;

    intr_prio_enc #(
        .N  (N_IRQ),
        .IW (ID_W)
    ) u_prio_enc (
        .req   (eligible_s),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    // Top-of-stack entry, selected by occupancy to avoid out-of-range indexing.
    always_comb begin
        top_s = {ID_W{1'b0}};
        for (int j = 0; j < int'(NEST_DEPTH); j++) begin
            top_s = (nest_level_r == LVL_W'(j + 1)) ? stack_r[j] : top_s;
        end
    end

    // Serviceability, request decode and call/return/error qualification.
    always_comb begin
        stack_empty_s = (nest_level_r == {LVL_W{1'b0}});
        req_s  = win_valid_s && (nest_level_r < LVL_W'(NEST_DEPTH)) &&
                 (stack_empty_s || (win_idx_s < top_s));
        id_s   = req_s ? win_idx_s : {ID_W{1'b0}};
        // Simultaneous ack and ret is an error and neither action is taken.
        err_s  = (ack && ret) || (ack && !req_s) || (ret && stack_empty_s);
        push_s = ack && !ret && req_s;
        pop_s  = ret && !ack && !stack_empty_s;
        push_mask_s = push_s ? (ONE_HOT0 << id_s) : {N_IRQ{1'b0}};
        pop_mask_s  = pop_s ? (ONE_HOT0 << top_s) : {N_IRQ{1'b0}};
    end

    // Two-flop input path feeding the rising-edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {N_IRQ{1'b0}};
            prev_r <= {N_IRQ{1'b0}};
        end else begin
            sync_r <= intr_in;
            prev_r <= sync_r;
        end
    end

    // Pending/mask/in-service bits; a new edge wins over the ack clear of the same line.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r    <= {N_IRQ{1'b0}};
            mask_r       <= {N_IRQ{1'b1}};
            in_service_r <= {N_IRQ{1'b0}};
            proto_err_r  <= 1'b0;
        end else begin
            pending_r    <= (pending_r & ~push_mask_s) | edge_s;
            mask_r       <= mask_we ? mask_in : mask_r;
            in_service_r <= (in_service_r | push_mask_s) & ~pop_mask_s;
            proto_err_r  <= proto_err_r | err_s;
        end
    end

    // Nest stack storage and occupancy pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            nest_level_r <= {LVL_W{1'b0}};
            for (int j = 0; j < int'(NEST_DEPTH); j++) begin
                stack_r[j] <= {ID_W{1'b0}};
            end
        end else begin
            for (int j = 0; j < int'(NEST_DEPTH); j++) begin
                if (push_s && (nest_level_r == LVL_W'(j))) begin
                    stack_r[j] <= id_s;
                end else begin
                    stack_r[j] <= stack_r[j];
                end
            end
            if (push_s) begin
                nest_level_r <= nest_level_r + LVL_W'(1);
            end else if (pop_s) begin
                nest_level_r <= nest_level_r - LVL_W'(1);
            end else begin
                nest_level_r <= nest_level_r;
            end
        end
    end

    assign irq_req    = req_s;
    assign irq_id     = id_s;
    assign irq_vector = VEC_BASE + ADDR_W'(id_s) * VEC_STRIDE;
    assign in_service = in_service_r;
    assign nest_level = nest_level_r;
    assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_intr_ctrl_nested.sv
// Self-checking bench for intr_ctrl_nested: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the controller.
module tb_intr_ctrl_nested;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] intr_in = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_in = 8'hFF;
    logic       ack = 1'b0;
    logic       ret = 1'b0;
    logic       irq_req;
    logic [2:0] irq_id;
    logic [15:0] irq_vector;
    logic [7:0] in_service;
    logic [2:0] nest_level;
    logic       proto_err;

    int vectors = 0;
    int miscompares = 0;

    // model state: pending/mask bit sets, input samples of last two edges, stack of lines
    bit [7:0] m_pend = 8'h00;
    bit [7:0] m_mask = 8'hFF;
    bit [7:0] m_s1 = 8'h00;
    bit [7:0] m_s2 = 8'h00;
    int       m_stack[$];
    bit       m_err = 1'b0;

    localparam logic [31:0] RESET_OUTS = {1'b0, 3'd0, 16'h0F00, 8'h00, 3'd0, 1'b0};

    intr_ctrl_nested dut (
        .clk        (clk),
        .reset      (reset),
        .intr_in    (intr_in),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .ack        (ack),
        .ret        (ret),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_vector (irq_vector),
        .in_service (in_service),
        .nest_level (nest_level),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    wire logic [31:0] dut_o = {irq_req, irq_id, irq_vector, in_service, nest_level, proto_err};

    function automatic int m_winner();
        for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    function automatic bit m_req();
        int w = m_winner();
        if (w < 0 || m_stack.size() >= 4) return 1'b0;
        if (m_stack.size() == 0) return 1'b1;
        return w < m_stack[m_stack.size()-1];
    endfunction

    function automatic logic [31:0] m_outs();
        int id = m_req() ? m_winner() : 0;
        logic [15:0] vec = 16'(32'h0F00 + id * 16);
        logic [7:0] isv = 8'h00;
        foreach (m_stack[k]) isv = isv | 8'(1 << m_stack[k]);
        return {m_req(), 3'(id), vec, isv, 3'(m_stack.size()), m_err};
    endfunction

    // one clock: drive inputs, advance model with pre-edge state, return at negedge
    task automatic tick(input logic [7:0] irq, input logic mwe, input logic [7:0] mval,
                        input logic a, input logic r, input logic rst);
        bit req;
        int w;
        intr_in = irq; mask_we = mwe; mask_in = mval; ack = a; ret = r; reset = rst;
        req = m_req();
        w = m_winner();
        @(posedge clk);
        if (rst) begin
            m_pend = 8'h00; m_mask = 8'hFF; m_s1 = 8'h00; m_s2 = 8'h00;
            m_stack.delete(); m_err = 1'b0;
        end else begin
            if ((a && r) || (a && !req) || (r && m_stack.size() == 0)) m_err = 1'b1;
            else if (a) begin m_pend[w] = 1'b0; m_stack.push_back(w); end
            else if (r) void'(m_stack.pop_back());
            if (mwe) m_mask = mval;
            m_pend = m_pend | (m_s1 & ~m_s2);
            m_s2 = m_s1;
            m_s1 = irq;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_ack();  tick(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0); endtask
    task automatic do_ret();  tick(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0); endtask
    task automatic do_rst();  tick(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1); endtask
    task automatic pulse(input logic [7:0] irq); tick(irq, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0); endtask

    task automatic test_reset();
        do_rst(); do_rst();
        vectors++;
        if (dut_o !== RESET_OUTS) begin
            $display("FAIL reset: got %h expected %h", dut_o, RESET_OUTS); miscompares++;
        end
    endtask

    task automatic test_single();
        pulse(8'h08);
        vectors++;
        if (irq_req !== 1'b0) begin
            $display("FAIL single_early: irq_req got %b expected 0", irq_req); miscompares++;
        end
        idle(1);
        vectors++;
        if ({irq_req, irq_id, irq_vector} !== {1'b1, 3'd3, 16'h0F30}) begin
            $display("FAIL single_req: got %b/%0d/%h expected 1/3/0f30",
                     irq_req, irq_id, irq_vector); miscompares++;
        end
        do_ack();
        vectors++;
        if (dut_o !== m_outs() || in_service !== 8'h08 || nest_level !== 3'd1) begin
            $display("FAIL single_ack: got %h expected %h", dut_o, m_outs()); miscompares++;
        end
        do_ret();
    endtask

    task automatic test_priority();
        pulse(8'h24); idle(1);
        vectors++;
        if ({irq_req, irq_id} !== {1'b1, 3'd2}) begin
            $display("FAIL prio_first: got %b/%0d expected 1/2", irq_req, irq_id); miscompares++;
        end
        do_ack();
        vectors++;
        if (irq_req !== 1'b0 || nest_level !== 3'd1) begin
            $display("FAIL prio_blocked: got req %b lvl %0d expected 0/1", irq_req, nest_level);
            miscompares++;
        end
        do_ret();
        vectors++;
        if ({irq_req, irq_id, irq_vector} !== {1'b1, 3'd5, 16'h0F50}) begin
            $display("FAIL prio_resume: got %b/%0d/%h expected 1/5/0f50",
                     irq_req, irq_id, irq_vector); miscompares++;
        end
        do_ack(); do_ret();
    endtask

    task automatic test_preempt();
        pulse(8'h10); idle(1); do_ack();
        pulse(8'h02); idle(1);
        vectors++;
        if ({irq_req, irq_id, in_service} !== {1'b1, 3'd1, 8'h10}) begin
            $display("FAIL preempt_req: got %b/%0d/%h expected 1/1/10",
                     irq_req, irq_id, in_service); miscompares++;
        end
        do_ack();
        vectors++;
        if (nest_level !== 3'd2 || in_service !== 8'h12) begin
            $display("FAIL preempt_nest: got lvl %0d isv %h expected 2/12", nest_level, in_service);
            miscompares++;
        end
        pulse(8'h40); idle(1); do_ret();
        vectors++;
        if (irq_req !== 1'b0 || nest_level !== 3'd1) begin
            $display("FAIL preempt_hold6: got req %b lvl %0d expected 0/1", irq_req, nest_level);
            miscompares++;
        end
        do_ret();
        vectors++;
        if ({irq_req, irq_id} !== {1'b1, 3'd6}) begin
            $display("FAIL preempt_line6: got %b/%0d expected 1/6", irq_req, irq_id); miscompares++;
        end
        do_ack(); do_ret();
    endtask

    task automatic test_full();
        for (int l = 6; l >= 3; l--) begin
            pulse(8'(1 << l)); idle(1); do_ack();
        end
        pulse(8'h01); idle(2);
        vectors++;
        if ({irq_req, nest_level, in_service} !== {1'b0, 3'd4, 8'h78}) begin
            $display("FAIL full_block: got %b/%0d/%h expected 0/4/78",
                     irq_req, nest_level, in_service); miscompares++;
        end
        do_ret();
        vectors++;
        if ({irq_req, irq_id, irq_vector} !== {1'b1, 3'd0, 16'h0F00}) begin
            $display("FAIL full_release: got %b/%0d/%h expected 1/0/0f00",
                     irq_req, irq_id, irq_vector); miscompares++;
        end
        do_ack();
        for (int k = 0; k < 4; k++) do_ret();
        vectors++;
        if (dut_o !== m_outs() || nest_level !== 3'd0) begin
            $display("FAIL full_unwind: got %h expected %h", dut_o, m_outs()); miscompares++;
        end
    endtask

    task automatic test_mask();
        tick(8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        pulse(8'h01); idle(2);
        vectors++;
        if (irq_req !== 1'b0) begin
            $display("FAIL mask_block: irq_req got %b expected 0", irq_req); miscompares++;
        end
        tick(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({irq_req, irq_id} !== {1'b1, 3'd0}) begin
            $display("FAIL mask_unmask: got %b/%0d expected 1/0", irq_req, irq_id); miscompares++;
        end
        do_ack(); do_ret();
    endtask

    task automatic test_errors();
        do_rst(); do_ret();
        vectors++;
        if (dut_o !== (RESET_OUTS | 32'h1)) begin
            $display("FAIL err_ret_empty: got %h expected %h", dut_o, RESET_OUTS | 32'h1);
            miscompares++;
        end
        do_rst(); do_ack();
        vectors++;
        if (dut_o !== (RESET_OUTS | 32'h1)) begin
            $display("FAIL err_ack_idle: got %h expected %h", dut_o, RESET_OUTS | 32'h1);
            miscompares++;
        end
        do_rst(); pulse(8'h04); idle(1);
        tick(8'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (dut_o !== {1'b1, 3'd2, 16'h0F20, 8'h00, 3'd0, 1'b1}) begin
            $display("FAIL err_ack_ret: got %h expected %h", dut_o,
                     {1'b1, 3'd2, 16'h0F20, 8'h00, 3'd0, 1'b1}); miscompares++;
        end
        do_ack(); pulse(8'h02); idle(1); do_ack(); pulse(8'h01); idle(1); do_ack();
        vectors++;
        if (nest_level !== 3'd3 || in_service !== 8'h07) begin
            $display("FAIL err_nest3: got lvl %0d isv %h expected 3/07", nest_level, in_service);
            miscompares++;
        end
        do_rst();
        vectors++;
        if (dut_o !== RESET_OUTS) begin
            $display("FAIL reset_mid_nest: got %h expected %h", dut_o, RESET_OUTS); miscompares++;
        end
    endtask

    task automatic test_random();
        logic [7:0] irq;
        logic a, r, mwe, rst;
        do_rst();
        irq = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) irq = irq ^ 8'($urandom & $urandom);
            a   = (m_req() && $urandom_range(0, 2) == 0) || ($urandom_range(0, 60) == 0);
            r   = (m_stack.size() != 0 && $urandom_range(0, 4) == 0) || ($urandom_range(0, 70) == 0);
            mwe = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 200) == 0);
            tick(irq, mwe, 8'($urandom) | 8'h81, a, r, rst);
            vectors++;
            if (dut_o !== m_outs()) begin
                $display("FAIL random cycle %0d: got %h expected %h", c, dut_o, m_outs());
                miscompares++;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_full();
        test_mask();
        test_errors();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
